// File: rtl/or1k_wb_slave_ram_if.sv
// Wishbone B3 32-bit bus bundle between the or1k master bridge and the RAM slave.
interface or1k_wb_slave_ram_if;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
        output wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
        input  wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/or1k_wb_slave_ram.sv
// Wishbone B3 slave terminating classic and registered-feedback burst cycles
// into a word-addressed RAM of 2**AW 32-bit words.
module or1k_wb_slave_ram #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               rst,
    or1k_wb_slave_ram_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] ba_q, ba_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;

    logic [31:0]   mem [2**AW];

    logic          req;
    logic          in_range;
    logic          wr_en;
    logic [AW-1:0] adr_w;
    logic [AW-1:0] wmask;
    logic [AW-1:0] nba;
    logic [AW:0]   inc;
    logic          nba_oor;
    logic          unused_adr;

    assign req        = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign adr_w      = bus.wbs_adr_i[AW+1:2];
    assign in_range   = (bus.wbs_adr_i[31:AW+2] == '0);
    assign unused_adr = ^bus.wbs_adr_i[1:0];

    // Next beat address: wrapping bursts only advance the low bits selected by
    // wmask; a linear burst uses an all-ones mask and may carry out of range.
    always_comb begin
        wmask = '1;
        case (bus.wbs_bte_i)
            2'b01:   wmask = AW'(3);
            2'b10:   wmask = AW'(7);
            2'b11:   wmask = AW'(15);
            default: wmask = '1;
        endcase
    end

    assign inc     = {1'b0, ba_q} + {{AW{1'b0}}, 1'b1};
    assign nba     = (ba_q & ~wmask) | (inc[AW-1:0] & wmask);
    assign nba_oor = inc[AW] & (bus.wbs_bte_i == 2'b00);

    // Access FSM: next state, termination outputs and read-data prefetch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ba_d    = ba_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    ba_d = adr_w;
                    if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = S_ACK;
                    end else if (WAIT_STATES > 0) begin
                        cnt_d   = 3'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end else begin
                        ack_d   = 1'b1;
                        dat_d   = mem[adr_w];
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    ack_d   = 1'b1;
                    dat_d   = mem[ba_q];
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK, S_BURST: begin
                // An error beat (ack_q low) always returns to idle untouched.
                state_d = S_IDLE;
                if (ack_q) begin
                    wr_en = req & bus.wbs_we_i;
                    if (req && bus.wbs_cti_i == 3'b010) begin
                        if (nba_oor) begin
                            err_d   = 1'b1;
                            state_d = S_ACK;
                        end else begin
                            ba_d    = nba;
                            ack_d   = 1'b1;
                            dat_d   = mem[nba];
                            state_d = S_BURST;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Dropping cyc abandons the access, including any un-acked write.
        if (!bus.wbs_cyc_i) begin
            state_d = S_IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ba_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ba_q    <= ba_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Byte-lane write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wbs_sel_i[b]) mem[ba_q][8*b +: 8] <= bus.wbs_dat_i[8*b +: 8];
            end
        end
    end

    assign bus.wbs_dat_o = dat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;
    assign bus.wbs_rty_o = 1'b0;
endmodule

// File: tb/tb_or1k_wb_slave_ram.sv
// Bench for or1k_wb_slave_ram: two instances (0 and 3 wait states) driven by an
// open-loop master whose per-cycle expectations come from a transaction model.
module tb_or1k_wb_slave_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cur = 1'b0;   // 0: no-wait instance, 1: three-wait instance

    always #5 clk = ~clk;

    or1k_wb_slave_ram_if b0();
    or1k_wb_slave_ram_if b3();

    or1k_wb_slave_ram #(.AW(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    or1k_wb_slave_ram #(.AW(10), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    logic [31:0] drv_adr = '0, drv_dat = '0;
    logic [3:0]  drv_sel = '0;
    logic        drv_we = 1'b0, drv_cyc = 1'b0, drv_stb = 1'b0;
    logic [2:0]  drv_cti = '0;
    logic [1:0]  drv_bte = '0;

    assign b0.wbs_cyc_i = drv_cyc & ~cur;
    assign b3.wbs_cyc_i = drv_cyc & cur;
    assign b0.wbs_stb_i = drv_stb;  assign b3.wbs_stb_i = drv_stb;
    assign b0.wbs_adr_i = drv_adr;  assign b3.wbs_adr_i = drv_adr;
    assign b0.wbs_dat_i = drv_dat;  assign b3.wbs_dat_i = drv_dat;
    assign b0.wbs_sel_i = drv_sel;  assign b3.wbs_sel_i = drv_sel;
    assign b0.wbs_we_i  = drv_we;   assign b3.wbs_we_i  = drv_we;
    assign b0.wbs_cti_i = drv_cti;  assign b3.wbs_cti_i = drv_cti;
    assign b0.wbs_bte_i = drv_bte;  assign b3.wbs_bte_i = drv_bte;

    logic [31:0] o_dat;
    logic        o_ack, o_err, o_rty;
    assign o_dat = cur ? b3.wbs_dat_o : b0.wbs_dat_o;
    assign o_ack = cur ? b3.wbs_ack_o : b0.wbs_ack_o;
    assign o_err = cur ? b3.wbs_err_o : b0.wbs_err_o;
    assign o_rty = cur ? b3.wbs_rty_o : b0.wbs_rty_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] mm [2][1024];   // model memory per instance

    logic        e_vld = 1'b0, e_ack = 1'b0, e_err = 1'b0, e_dchk = 1'b0;
    logic [31:0] e_dat = '0;
    logic [31:0] last_dat = '0;
    int          run = 0, run_last = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // Word address of beat i of a burst starting at w0.
    function automatic int beat_addr(input int w0, input logic [1:0] bt, input int i);
        int len;
        case (bt)
            2'b01:   len = 4;
            2'b10:   len = 8;
            2'b11:   len = 16;
            default: len = 0;
        endcase
        if (len == 0) return w0 + i;
        return (w0 - (w0 % len)) + ((w0 + i) % len);
    endfunction

    // Compare process: every cycle with an expectation is checked at negedge.
    always @(negedge clk) begin
        if (e_vld) begin
            chk("ack", 32'(o_ack), 32'(e_ack));
            chk("err", 32'(o_err), 32'(e_err));
            chk("rty", 32'(o_rty), 32'd0);
            if (e_dchk) chk("dat", o_dat, e_dat);
        end
        if (o_ack) begin
            last_dat = o_dat;
            run++;
        end else if (run > 0) begin
            run_last = run;
            run = 0;
        end
    end

    // One bus cycle: drive inputs shortly after the edge and publish the
    // outputs the model predicts for this same cycle.
    task automatic step(input logic c, input logic s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                        input logic [1:0] bt, input logic ea, input logic ee,
                        input logic dc, input logic [31:0] ed);
        @(posedge clk);
        #2;
        drv_cyc = c; drv_stb = s; drv_we = w; drv_adr = a; drv_dat = d;
        drv_sel = sl; drv_cti = ct; drv_bte = bt;
        e_ack = ea; e_err = ee; e_dchk = dc; e_dat = ed; e_vld = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, 0, '0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_ack"}, 32'(o_ack), 32'd0);
        chk({nm, "_err"}, 32'(o_err), 32'd0);
        chk({nm, "_rty"}, 32'(o_rty), 32'd0);
        chk({nm, "_dat"}, o_dat, 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle, held for two edges.
    task automatic do_reset();
        @(negedge clk);
        #1;
        e_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        step(0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, 1, '0);
        step(0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, 1, '0);
        rst = 1'b0;
    endtask

    // Classic single access; any cti other than 010 behaves as classic.
    task automatic classic(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        int ws;
        int w;
        logic [2:0] ct;
        logic [1:0] bt;
        ws = cur ? 3 : 0;
        w  = int'(a[11:2]);
        do ct = 3'($urandom); while (ct == 3'b010);
        bt = 2'($urandom);
        step(1, 1, we, a, d, sl, ct, bt, 0, 0, 0, '0);
        if (a[31:12] != '0) begin
            step(1, 1, we, a, d, sl, ct, bt, 0, 1, 0, '0);
        end else begin
            for (int k = 0; k < ws; k++) step(1, 1, we, a, d, sl, ct, bt, 0, 0, 0, '0);
            step(1, 1, we, a, d, sl, ct, bt, 1, 0, !we, mm[cur][w]);
            if (we) mm[cur][w] = merge(mm[cur][w], d, sl);
        end
        idle();
    endtask

    // Burst of n beats from word w0; abort_at drops cyc on that beat, rst_at
    // resets on that beat (both before the beat's write commits).
    task automatic burst(input logic we, input int w0, input int n, input logic [1:0] bt,
                         input bit full, input int abort_at, input int rst_at);
        int ws;
        int w;
        logic [31:0] a0, ad, d;
        logic [3:0] sl;
        logic [2:0] ct, ct0;
        ws  = cur ? 3 : 0;
        a0  = 32'(w0) << 2;
        ct0 = (n > 1) ? 3'b010 : 3'b111;
        step(1, 1, we, a0, $urandom, 4'hf, ct0, bt, 0, 0, 0, '0);
        for (int k = 0; k < ws; k++) step(1, 1, we, a0, $urandom, 4'hf, ct0, bt, 0, 0, 0, '0);
        for (int i = 0; i < n; i++) begin
            w  = beat_addr(w0, bt, i);
            d  = $urandom;
            sl = full ? 4'hf : 4'($urandom);
            ct = (i == n - 1) ? 3'b111 : 3'b010;
            ad = (i == 0) ? a0 : $urandom;
            if (w > 1023) begin
                step(1, 1, we, ad, d, sl, ct, bt, 0, 1, 0, '0);
                break;
            end
            if (i == abort_at) begin
                step(0, 0, we, ad, d, sl, ct, bt, 1, 0, !we, mm[cur][w]);
                break;
            end
            step(1, 1, we, ad, d, sl, ct, bt, 1, 0, !we, mm[cur][w]);
            if (i == rst_at) begin
                do_reset();
                break;
            end
            if (we) mm[cur][w] = merge(mm[cur][w], d, sl);
        end
        idle();
    endtask

    task automatic random_txns(input int count);
        int n, w0, ab;
        logic [31:0] a;
        logic [1:0] bt;
        for (int t = 0; t < count; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = {20'h0, 12'($urandom)};
                if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
                classic(1'($urandom), a, $urandom, 4'($urandom));
            end else begin
                bt = 2'($urandom);
                n  = $urandom_range(1, 20);
                w0 = (bt == 2'b00 && $urandom_range(0, 3) == 0) ? $urandom_range(1010, 1023)
                                                                : $urandom_range(0, 1023);
                ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
                burst(1'($urandom), w0, n, bt, 0, ab, -1);
            end
        end
    endtask

    initial begin
        int exp8 [8];
        logic [31:0] old;
        exp8 = '{5, 6, 7, 0, 1, 2, 3, 4};

        #1;
        chk_outputs_zero("rst_init");
        step(0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, 1, '0);
        step(0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, 1, '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) chk("wrap8_addr", 32'(beat_addr(5, 2'b10, i)), 32'(exp8[i]));
        chk("wrap4_addr", 32'(beat_addr(14, 2'b01, 3)), 32'd13);

        // ---------------- zero wait states ----------------
        cur = 1'b0;
        burst(1, 0, 1024, 2'b00, 1, -1, -1);
        classic(1, 32'h10, 32'hDEADBEEF, 4'hf);
        classic(0, 32'h10, '0, 4'h0);
        chk("rd_deadbeef", last_dat, 32'hDEADBEEF);
        classic(1, 32'h10, 32'h11223344, 4'b0101);
        classic(0, 32'h10, '0, 4'h0);
        chk("rd_lanes", last_dat, 32'hDE22BE44);

        burst(0, 5, 8, 2'b10, 0, -1, -1);
        @(negedge clk);
        #1;
        chk("wrap8_run", 32'(run_last), 32'd8);

        classic(0, 32'h1000, '0, 4'h0);
        burst(0, 1023, 3, 2'b00, 0, -1, -1);

        old = mm[0][43];
        burst(1, 40, 6, 2'b00, 0, 3, -1);
        classic(0, 32'd43 << 2, '0, 4'h0);
        chk("abort_unwritten", last_dat, old);

        random_txns(60);

        // ---------------- three wait states ----------------
        cur = 1'b1;
        idle();
        burst(1, 0, 1024, 2'b00, 1, -1, -1);
        classic(1, 32'h20, 32'hCAFEF00D, 4'hf);
        classic(0, 32'h20, '0, 4'h0);
        chk("ws3_rd", last_dat, 32'hCAFEF00D);
        burst(0, 100, 5, 2'b00, 0, -1, -1);
        classic(0, 32'h1000, '0, 4'h0);
        burst(0, 1023, 2, 2'b00, 0, -1, -1);
        random_txns(40);

        old = mm[1][202];
        burst(1, 200, 6, 2'b00, 0, -1, 2);
        classic(0, 32'd202 << 2, '0, 4'h0);
        chk("rst_dropped_write", last_dat, old);
        classic(0, 32'h20, '0, 4'h0);
        chk("post_rst_rd", last_dat, 32'hCAFEF00D);

        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
